cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_pkg.sv | 70 +++++++
 rtl/cpu_alu.sv | 53 +++++
 rtl/cpu_core.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_core.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, timing states, register indices and program image
// Purpose: common definitions for cpu_core and cpu_alu.
// Contents: opcode_e (4-bit opcode field), tstate_e (one-hot T states),
//           REG_* register indices, image_t and the default 256-byte program.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_INC = 4'h7,
    OP_DEC = 4'h8,
    OP_MVI = 4'h9,
    OP_LD  = 4'hA,
    OP_ST  = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_JC  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // One-hot timing states; T6/T7 are never entered by legal sequencing.
  typedef enum logic [7:0] {
    T0 = 8'h01,
    T1 = 8'h02,
    T2 = 8'h04,
    T3 = 8'h08,
    T4 = 8'h10,
    T5 = 8'h20,
    T6 = 8'h40,
    T7 = 8'h80
  } tstate_e;

  localparam logic [1:0] REG_AX = 2'd0;
  localparam logic [1:0] REG_BX = 2'd1;
  localparam logic [1:0] REG_CX = 2'd2;
  localparam logic [1:0] REG_DX = 2'd3;

  typedef logic [255:0][7:0] image_t;

  // Opcodes 9..E carry an immediate byte after the opcode byte.
  function automatic logic is_two_byte(input opcode_e op);
    return (op >= OP_MVI) && (op <= OP_JC);
  endfunction

  // Sums 10 down to 1 into AX, then halts.
  function automatic image_t default_image();
    image_t img;
    img     = '0;
    img[0]  = 8'h90;  // MVI AX,00
    img[1]  = 8'h00;
    img[2]  = 8'h93;  // MVI DX,0A
    img[3]  = 8'h0A;
    img[4]  = 8'h2C;  // ADD AX,DX
    img[5]  = 8'h83;  // DEC DX
    img[6]  = 8'hD0;  // JZ 0A
    img[7]  = 8'h0A;
    img[8]  = 8'hC0;  // JMP 04
    img[9]  = 8'h04;
    img[10] = 8'hF0;  // HLT
    return img;
  endfunction

  localparam image_t DEFAULT_IMAGE = default_image();

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational 8-bit ALU
// Purpose: computes the one-byte instruction result and its flags.
// Ports: opcode (in, opcode_e), a (in, 8, destination operand),
//        b (in, 8, source operand), result (out, 8), z (out, result==0),
//        c (out, carry/borrow/wrap; 0 for logic ops).
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_e    opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       z,
  output logic       c
);

  logic [8:0] wide;

  always_comb begin
    wide   = 9'd0;
    result = a;
    c      = 1'b0;
    case (opcode)
      OP_MOV: result = b;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the borrow out.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_INC: begin
        result = a + 8'd1;
        c      = (a == 8'hFF);
      end
      OP_DEC: begin
        result = a - 8'd1;
        c      = (a == 8'h00);
      end
      default: result = a;
    endcase
  end

  assign z = (result == 8'h00);

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 8-bit accumulator-style CPU with internal 256x8 RAM
// Purpose: fetch/execute core sequenced by a one-hot T-state counter.
// Ports: clk, RESET (sync, active-high), RUN (execution enable);
//        AX/DX (R0/R3), R (ALU result), ABUS (=MAR), DBUS (read data or store
//        data), D2BUS (live ALU output), T (one-hot state), ALU_A/ALU_B
//        (operand latches), PC2MAR (PC), IROUT (IR), IRX/SRC/DST (IR fields),
//        HALT (set by HLT).
// Parameter: IMAGE - power-up RAM contents.
module cpu_core
  import cpu_pkg::*;
#(
  parameter image_t IMAGE = DEFAULT_IMAGE
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       RUN,
  output logic [7:0] AX,
  output logic [7:0] DX,
  output logic [7:0] R,
  output logic [7:0] ABUS,
  output logic [7:0] DBUS,
  output logic [7:0] D2BUS,
  output logic [7:0] T,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [7:0] PC2MAR,
  output logic [7:0] IROUT,
  output logic [3:0] IRX,
  output logic [1:0] SRC,
  output logic [1:0] DST,
  output logic       HALT
);

  tstate_e          t_q, t_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       mar_q, mar_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       dlat_q, dlat_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [3:0][7:0]  regs_q, regs_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             halt_q, halt_d;

  // RAM contents come only from the configuration image; RESET leaves them alone.
  logic [255:0][7:0] mem_q = IMAGE;
  logic              mem_we;
  logic [7:0]        mem_waddr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  opcode_e    op;
  logic [1:0] src_idx;
  logic [1:0] dst_idx;
  logic       two_byte;
  logic [7:0] alu_y;
  logic       alu_z;
  logic       alu_c;

  assign op        = opcode_e'(ir_q[7:4]);
  assign src_idx   = ir_q[3:2];
  assign dst_idx   = ir_q[1:0];
  assign two_byte  = is_two_byte(op);
  assign mem_rdata = mem_q[mar_q];

  // The ALU reads the register file directly so R can be latched in T2.
  cpu_alu u_alu (
    .opcode (op),
    .a      (regs_q[dst_idx]),
    .b      (regs_q[src_idx]),
    .result (alu_y),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    t_d       = t_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    dlat_d    = dlat_q;
    r_d       = r_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    regs_d    = regs_q;
    z_d       = z_q;
    c_d       = c_q;
    halt_d    = halt_q;
    mem_we    = 1'b0;
    mem_waddr = mar_q;
    mem_wdata = regs_q[src_idx];

    if (RUN && !halt_q) begin
      case (t_q)
        T0: begin
          mar_d = pc_q;
          t_d   = T1;
        end
        T1: begin
          ir_d = mem_rdata;
          pc_d = pc_q + 8'd1;
          t_d  = T2;
        end
        T2: begin
          if (op == OP_HLT) begin
            // T stays at T2 while halted.
            halt_d = 1'b1;
          end else if (two_byte) begin
            mar_d = pc_q;
            t_d   = T3;
          end else begin
            alu_a_d = regs_q[dst_idx];
            alu_b_d = regs_q[src_idx];
            r_d     = alu_y;
            if ((op != OP_NOP) && (op != OP_MOV)) begin
              z_d = alu_z;
              c_d = alu_c;
            end
            t_d = T3;
          end
        end
        T3: begin
          if (two_byte) begin
            dlat_d = mem_rdata;
            pc_d   = pc_q + 8'd1;
            t_d    = T4;
          end else begin
            if (op != OP_NOP) begin
              regs_d[dst_idx] = r_q;
            end
            t_d = T0;
          end
        end
        T4: begin
          t_d = T0;
          case (op)
            OP_MVI: regs_d[dst_idx] = dlat_q;
            OP_JMP: pc_d = dlat_q;
            OP_JZ:  if (z_q) pc_d = dlat_q;
            OP_JC:  if (c_q) pc_d = dlat_q;
            OP_LD, OP_ST: begin
              mar_d = dlat_q;
              t_d   = T5;
            end
            default: t_d = T0;
          endcase
        end
        T5: begin
          t_d = T0;
          if (op == OP_LD) begin
            regs_d[dst_idx] = mem_rdata;
          end else if (op == OP_ST) begin
            mem_we = 1'b1;
          end
        end
        // T6, T7 and any corrupted encoding recover to T0.
        default: t_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      t_q     <= T0;
      pc_q    <= 8'h00;
      mar_q   <= 8'h00;
      ir_q    <= 8'h00;
      dlat_q  <= 8'h00;
      r_q     <= 8'h00;
      alu_a_q <= 8'h00;
      alu_b_q <= 8'h00;
      regs_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      t_q     <= t_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      dlat_q  <= dlat_d;
      r_q     <= r_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      regs_q  <= regs_d;
      z_q     <= z_d;
      c_q     <= c_d;
      halt_q  <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign AX     = regs_q[REG_AX];
  assign DX     = regs_q[REG_DX];
  assign R      = r_q;
  assign ABUS   = mar_q;
  assign DBUS   = ((t_q == T5) && (op == OP_ST)) ? regs_q[src_idx] : mem_rdata;
  assign D2BUS  = alu_y;
  assign T      = t_q;
  assign ALU_A  = alu_a_q;
  assign ALU_B  = alu_b_q;
  assign PC2MAR = pc_q;
  assign IROUT  = ir_q;
  assign IRX    = ir_q[7:4];
  assign SRC    = ir_q[3:2];
  assign DST    = ir_q[1:0];
  assign HALT   = halt_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - self-checking bench for cpu_core against an instruction-level model
module tb_cpu_core;

  typedef logic [255:0][7:0] img_t;

  function automatic img_t mk_a();
    img_t v;
    v = '0;
    v[10:0] = {8'hF0, 8'h04, 8'hC0, 8'h0A, 8'hD0, 8'h83, 8'h2C, 8'h0A, 8'h93, 8'h00, 8'h90};
    return v;
  endfunction

  // MVI AX,FF; MVI BX,01; ADD AX,BX; JC 0A; MVI DX,11; HLT; (0A) HLT
  function automatic img_t mk_b();
    img_t v;
    v = '0;
    v[10:0] = {8'hF0, 8'hF0, 8'h11, 8'h93, 8'h0A, 8'hE0, 8'h24, 8'h01, 8'h91, 8'hFF, 8'h90};
    return v;
  endfunction

  // MVI CX,5A; ST CX,[80]; LD DX,[80]; HLT
  function automatic img_t mk_c();
    img_t v;
    v = '0;
    v[6:0] = {8'hF0, 8'h80, 8'hA3, 8'h80, 8'hB8, 8'h5A, 8'h92};
    return v;
  endfunction

  localparam img_t IMG_A = mk_a();
  localparam img_t IMG_B = mk_b();
  localparam img_t IMG_C = mk_c();

  logic clk = 1'b0;
  logic reset;
  logic run;

  logic [7:0] ax_w [3];
  logic [7:0] dx_w [3];
  logic [7:0] r_w [3];
  logic [7:0] abus_w [3];
  logic [7:0] dbus_w [3];
  logic [7:0] d2bus_w [3];
  logic [7:0] t_w [3];
  logic [7:0] alu_a_w [3];
  logic [7:0] alu_b_w [3];
  logic [7:0] pc_w [3];
  logic [7:0] ir_w [3];
  logic [3:0] irx_w [3];
  logic [1:0] src_w [3];
  logic [1:0] dst_w [3];
  logic       halt_w [3];

  always #5 clk = ~clk;

  cpu_core u_a (
    .clk(clk), .RESET(reset), .RUN(run),
    .AX(ax_w[0]), .DX(dx_w[0]), .R(r_w[0]), .ABUS(abus_w[0]), .DBUS(dbus_w[0]),
    .D2BUS(d2bus_w[0]), .T(t_w[0]), .ALU_A(alu_a_w[0]), .ALU_B(alu_b_w[0]),
    .PC2MAR(pc_w[0]), .IROUT(ir_w[0]), .IRX(irx_w[0]), .SRC(src_w[0]),
    .DST(dst_w[0]), .HALT(halt_w[0])
  );

  cpu_core #(.IMAGE(IMG_B)) u_b (
    .clk(clk), .RESET(reset), .RUN(run),
    .AX(ax_w[1]), .DX(dx_w[1]), .R(r_w[1]), .ABUS(abus_w[1]), .DBUS(dbus_w[1]),
    .D2BUS(d2bus_w[1]), .T(t_w[1]), .ALU_A(alu_a_w[1]), .ALU_B(alu_b_w[1]),
    .PC2MAR(pc_w[1]), .IROUT(ir_w[1]), .IRX(irx_w[1]), .SRC(src_w[1]),
    .DST(dst_w[1]), .HALT(halt_w[1])
  );

  cpu_core #(.IMAGE(IMG_C)) u_c (
    .clk(clk), .RESET(reset), .RUN(run),
    .AX(ax_w[2]), .DX(dx_w[2]), .R(r_w[2]), .ABUS(abus_w[2]), .DBUS(dbus_w[2]),
    .D2BUS(d2bus_w[2]), .T(t_w[2]), .ALU_A(alu_a_w[2]), .ALU_B(alu_b_w[2]),
    .PC2MAR(pc_w[2]), .IROUT(ir_w[2]), .IRX(irx_w[2]), .SRC(src_w[2]),
    .DST(dst_w[2]), .HALT(halt_w[2])
  );

  int npass = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference model.
  logic [7:0] m_mem [256];
  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic       m_z, m_c, m_halt;

  task automatic m_load(input img_t img);
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
  endtask

  // Executes one instruction and returns how many enabled clocks it takes.
  task automatic m_step(output int cyc);
    logic [7:0] op, imm;
    logic [1:0] sr, ds;
    int s;
    op = m_mem[m_pc];
    m_pc = m_pc + 8'd1;
    sr = op[3:2];
    ds = op[1:0];
    imm = 8'h00;
    cyc = 4;
    if (op[7:4] >= 4'h9 && op[7:4] <= 4'hE) begin
      imm = m_mem[m_pc];
      m_pc = m_pc + 8'd1;
      cyc = (op[7:4] == 4'hA || op[7:4] == 4'hB) ? 6 : 5;
    end
    case (op[7:4])
      4'h1: m_reg[ds] = m_reg[sr];
      4'h2: begin
        s = int'(m_reg[ds]) + int'(m_reg[sr]);
        m_c = (s > 255); m_reg[ds] = 8'(s); m_z = (m_reg[ds] == 8'h00);
      end
      4'h3: begin
        m_c = (m_reg[ds] < m_reg[sr]); m_reg[ds] = m_reg[ds] - m_reg[sr]; m_z = (m_reg[ds] == 8'h00);
      end
      4'h4: begin m_reg[ds] = m_reg[ds] & m_reg[sr]; m_c = 1'b0; m_z = (m_reg[ds] == 8'h00); end
      4'h5: begin m_reg[ds] = m_reg[ds] | m_reg[sr]; m_c = 1'b0; m_z = (m_reg[ds] == 8'h00); end
      4'h6: begin m_reg[ds] = m_reg[ds] ^ m_reg[sr]; m_c = 1'b0; m_z = (m_reg[ds] == 8'h00); end
      4'h7: begin m_c = (m_reg[ds] == 8'hFF); m_reg[ds] = m_reg[ds] + 8'd1; m_z = (m_reg[ds] == 8'h00); end
      4'h8: begin m_c = (m_reg[ds] == 8'h00); m_reg[ds] = m_reg[ds] - 8'd1; m_z = (m_reg[ds] == 8'h00); end
      4'h9: m_reg[ds] = imm;
      4'hA: m_reg[ds] = m_mem[imm];
      4'hB: m_mem[imm] = m_reg[sr];
      4'hC: m_pc = imm;
      4'hD: if (m_z) m_pc = imm;
      4'hE: if (m_c) m_pc = imm;
      4'hF: begin m_halt = 1'b1; cyc = 3; end
      default: ;
    endcase
  endtask

  task automatic m_to_halt();
    int cyc;
    for (int i = 0; i < 1000 && !m_halt; i++) m_step(cyc);
  endtask

  // Applies one instruction's worth of enabled clocks with random RUN=0 gaps;
  // during a gap T must sit at the step reached and AX/DX at their pre-instruction values.
  task automatic run_instr(input int cyc, input logic [7:0] pre_ax, input logic [7:0] pre_dx,
                           input int long_at);
    for (int k = 0; k < cyc; k++) begin
      int np;
      if (k == long_at) np = 50;
      else if ($urandom_range(0, 3) == 0) np = int'($urandom_range(1, 3));
      else np = 0;
      if (np > 0) begin
        run = 1'b0;
        for (int p = 0; p < np; p++) begin
          tick();
          chk("pause_hold", 48'({t_w[0], ax_w[0], dx_w[0]}), 48'({8'(1 << k), pre_ax, pre_dx}));
        end
      end
      run = 1'b1;
      tick();
    end
  endtask

  logic [7:0] eb_ax, eb_dx, eb_pc, ec_dx, ec_m80;
  logic       eb_z, eb_c;

  initial begin
    int cyc, n;
    logic [7:0] pre_ax, pre_dx, pre_pc;
    logic timeout;

    reset = 1'b1;
    run   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_t",    48'(t_w[0]),    48'h01);
    chk("rst_pc",   48'(pc_w[0]),   48'h00);
    chk("rst_axdx", 48'({ax_w[0], dx_w[0]}), 48'h0000);
    chk("rst_halt", 48'(halt_w[0]), 48'h0);
    chk("rst_lat",  48'({r_w[0], alu_a_w[0], alu_b_w[0], ir_w[0], abus_w[0]}), 48'h0);

    m_load(IMG_B);
    m_to_halt();
    eb_ax = m_reg[0]; eb_dx = m_reg[3]; eb_pc = m_pc; eb_z = m_z; eb_c = m_c;
    m_load(IMG_C);
    m_to_halt();
    ec_dx = m_reg[3]; ec_m80 = m_mem[8'h80];
    m_load(IMG_A);

    for (int i = 0; i < 2; i++) begin
      pre_ax = m_reg[0]; pre_dx = m_reg[3];
      m_step(cyc);
      run_instr(cyc, pre_ax, pre_dx, -1);
      chk("instr_mvi", 48'({t_w[0], ax_w[0], dx_w[0], pc_w[0]}), 48'({8'h01, m_reg[0], m_reg[3], m_pc}));
    end

    // Single-step ADD AX,DX one enabled clock at a time.
    run = 1'b0;
    tick();
    pre_ax = m_reg[0]; pre_dx = m_reg[3]; pre_pc = m_pc;
    m_step(cyc);
    run = 1'b1; tick(); run = 1'b0;
    chk("ss_t1", 48'({t_w[0], abus_w[0], dbus_w[0]}), 48'({8'h02, pre_pc, m_mem[pre_pc]}));
    run = 1'b1; tick(); run = 1'b0;
    chk("ss_t2", 48'({t_w[0], ir_w[0], pc_w[0]}), 48'({8'h04, m_mem[pre_pc], 8'(pre_pc + 8'd1)}));
    chk("ss_fields", 48'({irx_w[0], src_w[0], dst_w[0]}),
        48'({m_mem[pre_pc][7:4], m_mem[pre_pc][3:2], m_mem[pre_pc][1:0]}));
    chk("ss_d2bus", 48'(d2bus_w[0]), 48'(8'(pre_ax + pre_dx)));
    run = 1'b1; tick(); run = 1'b0;
    chk("ss_t3", 48'({t_w[0], alu_a_w[0], alu_b_w[0], r_w[0], ax_w[0]}),
        48'({8'h08, pre_ax, pre_dx, m_reg[0], pre_ax}));
    run = 1'b1; tick(); run = 1'b0;
    chk("ss_wb", 48'({t_w[0], ax_w[0]}), 48'({8'h01, m_reg[0]}));

    n = 0;
    while (!m_halt && n < 200) begin
      pre_ax = m_reg[0]; pre_dx = m_reg[3];
      m_step(cyc);
      run_instr(cyc, pre_ax, pre_dx, (n == 6) ? 2 : -1);
      if (m_halt)
        chk("instr_hlt", 48'({t_w[0], ax_w[0], dx_w[0], pc_w[0], 7'd0, halt_w[0]}),
            48'({8'h04, m_reg[0], m_reg[3], m_pc, 8'h01}));
      else
        chk("instr", 48'({t_w[0], ax_w[0], dx_w[0], pc_w[0]}), 48'({8'h01, m_reg[0], m_reg[3], m_pc}));
      n++;
    end

    chk("sum_final", 48'({ax_w[0], dx_w[0], pc_w[0], t_w[0]}), 48'h37000B04);
    run = 1'b1;
    repeat (5) tick();
    chk("halt_frozen", 48'({t_w[0], pc_w[0], ax_w[0], 7'd0, halt_w[0]}), 48'h040B3701);

    chk("b_model", 48'({ax_w[1], dx_w[1], pc_w[1], 5'd0, halt_w[1], u_b.z_q, u_b.c_q}),
        48'({eb_ax, eb_dx, eb_pc, 5'd0, 1'b1, eb_z, eb_c}));
    chk("b_jc", 48'({ax_w[1], 6'd0, u_b.z_q, u_b.c_q, pc_w[1]}), 48'h00030B);
    chk("c_model", 48'({dx_w[2], u_c.mem_q[8'h80], 7'd0, halt_w[2]}), 48'({ec_dx, ec_m80, 8'h01}));
    chk("c_stld", 48'({dx_w[2], u_c.mem_q[8'h80]}), 48'h5A5A);

    // Reset mid-run.
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    chk("ram_kept", 48'(u_c.mem_q[8'h80]), 48'h5A);
    run = 1'b1;
    repeat (23) tick();
    chk("pre_rst_ax", 48'(ax_w[0]), 48'h0A);
    reset = 1'b1;
    tick();
    chk("midrst", 48'({t_w[0], pc_w[0], ax_w[0], 7'd0, halt_w[0]}), 48'h01000000);
    chk("midrst_b_halt", 48'(halt_w[1]), 48'h0);
    reset = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (halt_w[0]) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
    chk("rerun_timeout", 48'(timeout), 48'h0);
    chk("rerun_ax", 48'({ax_w[0], pc_w[0], t_w[0]}), 48'h370B04);
    chk("rerun_bc", 48'({pc_w[1], dx_w[2]}), 48'h0B5A);

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
